mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Sequential load/store access unit between the MEM pipeline stage and the data-memory bus.
- Generates byte enables and write-data lane placement for stores.
- Sign- or zero-extends load data.
- Parametrised in data width; optionally splits misaligned accesses into two aligned bus beats and merges the results.
- One transaction in flight; valid/ready request handshake and valid/ack bus handshake.

Parameters:
- DATA_W, 32: bus/data width; 32 or 64. NB = DATA_W/8 lanes, OFF_W = log2(NB).
- ADDR_W, 32: byte-address width.
- ALLOW_MISALIGN, 1: 1 = split misaligned accesses into two beats; 0 = flag them as errors.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  byte address.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64).
- req_unsigned  in  1  load zero-extends when 1.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned (ALLOW_MISALIGN=0) or illegal size.
- bus_valid  out  1  bus beat request.
- bus_ack  in  1  beat completes this cycle; bus_rdata is valid in the same cycle.
- bus_addr  out  ADDR_W  lane-aligned address (low OFF_W bits are 0).
- bus_we  out  1  write beat.
- bus_be  out  NB  byte enables, bit i = lane i, little-endian.
- bus_wdata  out  DATA_W  lane-placed store data.
- bus_rdata  in  DATA_W  read data.

Behaviour:
- Reset (async, immediate): FSM to IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0, bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
- Captured on accept: addr, size, unsigned, write and wdata. Derived values:
  - nbytes = 1<<size.
  - off = addr[OFF_W-1:0].
  - split = (off + nbytes > NB).
  - misaligned = (addr mod nbytes != 0).
- Store lane placement: {hi, lo} = zero-extended wdata[nbytes*8-1:0], shifted left by off*8 within 2*DATA_W. Byte-enable mask m = ((1<<nbytes)-1) << off, 2*NB bits wide. Beat0 uses lo / m[NB-1:0]; beat1 uses hi / m[2NB-1:NB].
- FSM states IDLE, BEAT0, BEAT1, RESP:
  - IDLE: req_ready=1. On accept:
    - size illegal, or (misaligned && !ALLOW_MISALIGN): go to RESP with err=1. No bus activity.
    - otherwise: go to BEAT0.
  - BEAT0: bus_valid=1, bus_addr = addr with low OFF_W bits cleared. Outputs stay stable until bus_ack. On ack, latch rdata into buf0, then go to BEAT1 if split, else RESP.
  - BEAT1: bus_addr = beat0 address + NB, wrapping modulo 2^ADDR_W. On ack, latch buf1 and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle; no back-pressure. Then go to IDLE; req_ready returns the following cycle.
- Load merge: r = ({buf1, buf0} >> off*8)[nbytes*8-1:0]. buf1 is 0 when not split. The top byte of r is sign-extended, or zero-extended when unsigned, to DATA_W. A dword load on DATA_W=64 passes through unchanged.
- Latency from the accept edge T: bus_valid high from T+1. With zero wait states, resp_valid is at T+2 for a single beat and T+3 for a split. Each wait cycle without ack adds one cycle.
- Error path: resp_valid at T+2, resp_err=1, resp_rdata=0.
- bus_valid is never asserted in IDLE or RESP. bus_ack outside BEAT0/BEAT1 is ignored.
- Asserting rst_n low mid-transaction aborts it: bus_valid drops immediately, no resp_valid is produced, and buffers clear.

Test Plan:
- DATA_W=32, zero-wait bus; load word at 0x1000 with bus_rdata=0x89ABCDEF -> single beat, bus_be=1111, resp_valid at T+2, resp_rdata=0x89ABCDEF.
- Load byte at 0x2001 with rdata 0x12348067 -> resp_rdata=0xFFFFFF80. Same request with unsigned=1 -> 0x00000080. Unsigned half load at 0x2002 -> 0x00001234.
- Store word 0xAABBCCDD to 0x1003, ALLOW_MISALIGN=1:
  - beat0: addr 0x1000, be=1000, wdata 0xDD000000.
  - beat1: addr 0x1004, be=0111, wdata 0x00AABBCC.
  - resp at T+3.
- Signed half load at 0x3003, 2 wait states per beat, rdata0=0xAB000000, rdata1=0x000000CD -> resp_rdata=0xFFFFCDAB. resp_valid at T+7.
- ALLOW_MISALIGN=0, half load at 0x0001 -> no bus_valid, resp_err=1 at T+2. size=3 with DATA_W=32 -> resp_err=1.
- Reset pulsed while in BEAT0 with bus_ack held low -> bus_valid=0 the same cycle, no resp_valid. A following aligned request completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store access unit between the MEM stage and the
// data-memory bus. Places store data on byte lanes with byte enables,
// sign/zero-extends load data, and optionally splits misaligned accesses
// into two aligned bus beats whose read data is merged.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake (accept = valid && ready)
//   req_addr/write/size/unsigned/wdata   request fields, wdata right-justified
//   resp_valid/rdata/err       one-cycle completion pulse with result
//   bus_valid/ack              bus beat handshake, bus_rdata valid with ack
//   bus_addr/we/be/wdata       lane-aligned beat address, write, enables, data
//   bus_rdata                  beat read data
module mem_access_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              bus_valid,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  state_t              r_state;
  logic [3:0]          r_alo;
  logic [1:0]          r_size;
  logic                r_uns;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_buf0;
  logic [DATA_W-1:0]   r_buf1;

  // Request fields come straight from the inputs while idle so the first
  // beat can be launched on the accept edge; afterwards from the captures.
  logic                w_idle;
  logic [3:0]          w_alo;
  logic [1:0]          w_size;
  logic [DATA_W-1:0]   w_wdata;
  logic [3:0]          w_nbytes;
  logic [OFF_W-1:0]    w_off;
  logic                w_split;
  logic                w_misal;
  logic                w_legal;
  logic                w_bad;
  logic [2*DATA_W-1:0] w_dl;
  logic [2*DATA_W-1:0] w_pl;
  logic [2*NB-1:0]     w_m0;
  logic [2*NB-1:0]     w_m;
  logic [2*DATA_W-1:0] w_cat;
  logic [DATA_W-1:0]   w_sh;
  logic                w_sign;
  logic [7:0]          w_fill;
  logic [DATA_W-1:0]   w_ext;

  assign w_idle   = (r_state == S_IDLE);
  assign w_alo    = w_idle ? req_addr[3:0] : r_alo;
  assign w_size   = w_idle ? req_size      : r_size;
  assign w_wdata  = w_idle ? req_wdata     : r_wdata;
  assign w_nbytes = 4'd1 << w_size;
  assign w_off    = w_alo[OFF_W-1:0];
  assign w_split  = (5'(w_off) + 5'(w_nbytes)) > 5'(NB);
  assign w_misal  = (w_alo & (w_nbytes - 4'd1)) != 4'd0;
  assign w_legal  = (w_size != 2'd3) || (DATA_W == 64);
  assign w_bad    = !w_legal || (w_misal && (ALLOW_MISALIGN == 0));

  // Store placement and byte-enable mask across a two-beat window.
  always_comb begin
    w_dl = '0;
    w_m0 = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b < 32'(w_nbytes)) begin
        w_dl[b*8 +: 8] = w_wdata[b*8 +: 8];
        w_m0[b]        = 1'b1;
      end
    end
    w_pl = w_dl << {w_off, 3'b000};
    w_m  = w_m0 << w_off;
  end

  // Load merge: r_buf1 is cleared on accept, so in BEAT0 the upper half is 0.
  assign w_cat = (r_state == S_BEAT1) ? {bus_rdata, r_buf0} : {r_buf1, bus_rdata};
  assign w_sh  = DATA_W'(w_cat >> {w_off, 3'b000});

  always_comb begin
    w_sign = 1'b0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b == 32'(w_nbytes) - 32'd1) w_sign = w_sh[b*8+7];
    end
    w_fill = (w_sign && !r_uns) ? 8'hFF : 8'h00;
    w_ext  = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      w_ext[b*8 +: 8] = (b < 32'(w_nbytes)) ? w_sh[b*8 +: 8] : w_fill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_alo      <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      bus_valid  <= 1'b0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_be     <= '0;
      bus_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_alo     <= req_addr[3:0];
            r_size    <= req_size;
            r_uns     <= req_unsigned;
            r_write   <= req_write;
            r_wdata   <= req_wdata;
            r_buf0    <= '0;
            r_buf1    <= '0;
            req_ready <= 1'b0;
            if (w_bad) begin
              r_state  <= S_RESP;
              resp_err <= 1'b1;
            end else begin
              r_state   <= S_BEAT0;
              bus_valid <= 1'b1;
              bus_we    <= req_write;
              bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              bus_be    <= w_m[NB-1:0];
              bus_wdata <= req_write ? w_pl[DATA_W-1:0] : '0;
            end
          end
        end
        S_BEAT0: begin
          if (bus_ack) begin
            r_buf0 <= bus_rdata;
            if (w_split) begin
              r_state   <= S_BEAT1;
              bus_addr  <= bus_addr + ADDR_W'(NB);
              bus_be    <= w_m[2*NB-1:NB];
              bus_wdata <= r_write ? w_pl[2*DATA_W-1:DATA_W] : '0;
            end else begin
              r_state    <= S_RESP;
              bus_valid  <= 1'b0;
              bus_we     <= 1'b0;
              bus_be     <= '0;
              bus_wdata  <= '0;
              resp_valid <= 1'b1;
              resp_rdata <= r_write ? '0 : w_ext;
            end
          end
        end
        S_BEAT1: begin
          if (bus_ack) begin
            r_buf1     <= bus_rdata;
            r_state    <= S_RESP;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= r_write ? '0 : w_ext;
          end
        end
        S_RESP: begin
          // Beat paths arrive with the pulse already raised; the error path
          // arrives without it and raises it here, matching the beat latency.
          if (resp_valid) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            resp_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
